eth_pcs_block_lock: RTL and testbench

Parametrised RX block-synchronisation engine for the 10GBASE-R PCS receive path. It sits between the RX gearbox and the descrambler/decoder. It inspects the 2-bit sync header of every block the gearbox presents, runs the block-lock state machine with configurable good/invalid thresholds, and pulses a slip request back to the gearbox until alignment is found. It generalises the fixed 64/16 thresholds to parameters, adds a slip-settle hold-off, and adds an optional high-BER monitor.

---
 rtl/eth_pcs_block_lock.sv | 150 +++++++++++++++
 tb/tb_eth_pcs_block_lock.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_block_lock.sv
// 10GBASE-R RX block-lock engine: sync-header checking, lock FSM and gearbox slip requests.
// Optional hi-BER monitor is compiled in with `define PCS_BLOCK_LOCK_HI_BER_EN.
module eth_pcs_block_lock #(
  parameter int SH_TH         = 64,
  parameter int SH_INVAL_TH   = 16,
  parameter int SLIP_HOLD     = 2,
  parameter int BER_TIMER_CYC = 19531,
  parameter int BER_TH        = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sh_valid,
  input  logic [1:0] i_sync,
  output logic       o_slip,
  output logic       o_blk_lock,
  output logic       o_hi_ber
);

  localparam int SH_W   = $clog2(SH_TH + 1);
  localparam int INV_W  = $clog2(SH_INVAL_TH + 1);
  localparam int HOLD_W = (SLIP_HOLD > 0) ? $clog2(SLIP_HOLD + 1) : 1;

  typedef enum logic [1:0] {ST_LOCK_INIT, ST_TEST, ST_SLIP_HOLD} state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d, sh_inc;
  logic [INV_W-1:0]    inval_cnt_q, inval_cnt_d, inval_inc;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                lock_q, lock_d, slip_q, slip_d;
  logic                hdr_ok, test_ev, slip_ev, win_ev, hold_done;

  assign hdr_ok    = i_sync[1] ^ i_sync[0];
  assign sh_inc    = sh_cnt_q + 1'b1;
  assign inval_inc = inval_cnt_q + 1'b1;
  assign test_ev   = (state_q == ST_TEST) && i_sh_valid;
  // Loss of lock takes priority over a window completing on the same header.
  assign slip_ev   = test_ev && !hdr_ok && (!lock_q || (inval_inc == INV_W'(SH_INVAL_TH)));
  assign win_ev    = test_ev && !slip_ev && (sh_inc == SH_W'(SH_TH));
  assign hold_done = (hold_cnt_q <= HOLD_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_LOCK_INIT;
      sh_cnt_q    <= '0;
      inval_cnt_q <= '0;
      hold_cnt_q  <= '0;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      inval_cnt_q <= inval_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      lock_q      <= lock_d;
      slip_q      <= slip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOCK_INIT: state_d = ST_TEST;
      ST_TEST:      if (slip_ev) state_d = ST_SLIP_HOLD;
      ST_SLIP_HOLD: if (i_sh_valid && hold_done) state_d = ST_TEST;
      default:      state_d = ST_LOCK_INIT;
    endcase
  end

  always_comb begin
    sh_cnt_d    = sh_cnt_q;
    inval_cnt_d = inval_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    lock_d      = lock_q;
    slip_d      = 1'b0;
    case (state_q)
      ST_LOCK_INIT: begin
        sh_cnt_d    = '0;
        inval_cnt_d = '0;
        hold_cnt_d  = '0;
        lock_d      = 1'b0;
      end
      ST_TEST: begin
        if (slip_ev) begin
          slip_d      = 1'b1;
          lock_d      = 1'b0;
          sh_cnt_d    = '0;
          inval_cnt_d = '0;
          hold_cnt_d  = HOLD_W'(SLIP_HOLD);
        end else if (win_ev) begin
          lock_d      = 1'b1;
          sh_cnt_d    = '0;
          inval_cnt_d = '0;
        end else if (test_ev) begin
          sh_cnt_d = sh_inc;
          if (!hdr_ok) inval_cnt_d = inval_inc;
        end
      end
      ST_SLIP_HOLD: begin
        if (i_sh_valid && (hold_cnt_q != '0)) hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: begin
        sh_cnt_d    = '0;
        inval_cnt_d = '0;
        hold_cnt_d  = '0;
        lock_d      = 1'b0;
      end
    endcase
  end

  assign o_slip     = slip_q;
  assign o_blk_lock = lock_q;

`ifdef PCS_BLOCK_LOCK_HI_BER_EN
  localparam int BT_W = (BER_TIMER_CYC > 1) ? $clog2(BER_TIMER_CYC) : 1;
  localparam int BC_W = $clog2(BER_TH + 1);

  logic [BT_W-1:0] ber_tmr_q, ber_tmr_d;
  logic [BC_W-1:0] ber_cnt_q, ber_cnt_d, ber_nxt;
  logic            hi_ber_q, hi_ber_d, ber_expire, ber_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ber_tmr_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      ber_tmr_q <= ber_tmr_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  // The invalid header arriving on the expiry cycle still belongs to the ending window.
  always_comb begin
    ber_expire = (ber_tmr_q == BT_W'(BER_TIMER_CYC - 1));
    ber_tmr_d  = ber_expire ? '0 : ber_tmr_q + 1'b1;
    ber_hit    = test_ev && !hdr_ok && lock_q;
    ber_nxt    = (ber_hit && (ber_cnt_q != BC_W'(BER_TH))) ? ber_cnt_q + 1'b1 : ber_cnt_q;
    hi_ber_d   = hi_ber_q;
    if (ber_nxt == BC_W'(BER_TH)) hi_ber_d = 1'b1;
    else if (ber_expire)          hi_ber_d = 1'b0;
    ber_cnt_d  = (ber_expire || (slip_ev && lock_q)) ? '0 : ber_nxt;
  end

  assign o_hi_ber = hi_ber_q;
`else
  assign o_hi_ber = 1'b0;
`endif

endmodule

// File: tb/tb_eth_pcs_block_lock.sv
// Scoreboard bench for eth_pcs_block_lock: the driver queues hand-derived expected outputs,
// a negedge monitor pops and compares them against the registered outputs.
module tb_eth_pcs_block_lock;

  localparam int BER_CYC = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       sh_valid;
  logic [1:0] sync;
  logic       slip, blk_lock, hi_ber;

  always #5 clk = ~clk;

  eth_pcs_block_lock #(
    .SH_TH(64), .SH_INVAL_TH(16), .SLIP_HOLD(2), .BER_TIMER_CYC(BER_CYC), .BER_TH(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sh_valid(sh_valid), .i_sync(sync),
    .o_slip(slip), .o_blk_lock(blk_lock), .o_hi_ber(hi_ber)
  );

  typedef struct {
    int    due;
    logic  e_slip;
    logic  e_lock;
    logic  e_ber;
    bit    chk_ber;
    string tag;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  string phase = "init";
  bit    ber_late_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got slip/lock/hi_ber=%b required %b", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, {slip, blk_lock, mon_e.chk_ber ? hi_ber : 1'b0},
          {mon_e.e_slip, mon_e.e_lock, mon_e.chk_ber ? mon_e.e_ber : 1'b0});
    end
  end

  task automatic step(input logic v, input logic [1:0] s, input logic es, input logic el,
                      input logic eb, input bit cb, input int idx);
    exp_t e;
    sh_valid  = v;
    sync      = s;
    e.due     = cyc + 1;
    e.e_slip  = es;
    e.e_lock  = el;
    e.e_ber   = eb;
    e.chk_ber = cb;
    e.tag     = $sformatf("%s[%0d]", phase, idx);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] good(input int i);
    return (i % 2 != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] bad(input int i);
    return (i % 2 != 0) ? 2'b11 : 2'b00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   is_bad;
    logic eb;
`ifdef PCS_BLOCK_LOCK_HI_BER_EN
    ber_late_chk = 1'b0;
`else
    ber_late_chk = 1'b1;
`endif
    rst = 1'b1; sh_valid = 1'b0; sync = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {slip, blk_lock, hi_ber}, 3'b000);
    rst = 1'b0;

    // Initial lock, then hi-BER windows; step p lands on the p-th edge after reset release.
    phase = "lock_ber";
    for (int p = 1; p <= 362; p++) begin
      is_bad = (p >= 115 && p <= 122) || (p >= 131 && p <= 138) ||
               p == 250 || p == 260 || p == 270;
`ifdef PCS_BLOCK_LOCK_HI_BER_EN
      eb = (p >= 138 && p < 300);
`else
      eb = 1'b0;
`endif
      step(p >= 3, (p < 3) ? 2'b00 : (is_bad ? bad(p) : good(p)), 1'b0, p >= 66, eb, 1'b1, p);
    end

    // Asynchronous reset while locked with 40 headers into the window.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", {slip, blk_lock, hi_ber}, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    phase = "relock_full";
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ber_late_chk, 0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, ber_late_chk, 0);
    for (int i = 1; i <= 64; i++)
      step(1'b1, good(i), 1'b0, i == 64, 1'b0, ber_late_chk, i);

    phase = "win15";
    for (int i = 1; i <= 64; i++)
      step(1'b1, (i % 4 == 1 && i <= 57) ? bad(i) : good(i), 1'b0, 1'b1, 1'b0, ber_late_chk, i);

    phase = "win16";
    for (int i = 1; i <= 31; i++)
      step(1'b1, (i % 2 == 1) ? bad(i) : good(i), i == 31, i != 31, 1'b0, ber_late_chk, i);

    phase = "hold_a";
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, ber_late_chk, 1);
    step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, ber_late_chk, 2);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, ber_late_chk, 3);

    phase = "relock_a";
    for (int i = 1; i <= 64; i++)
      step(1'b1, good(i), 1'b0, i == 64, 1'b0, ber_late_chk, i);

    phase = "prio";
    for (int i = 1; i <= 64; i++)
      step(1'b1, (i >= 49) ? bad(i) : good(i), i == 64, i != 64, 1'b0, ber_late_chk, i);

    phase = "hold_b";
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, ber_late_chk, 1);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, ber_late_chk, 2);

    phase = "unlocked_slip";
    for (int i = 1; i <= 11; i++)
      step(1'b1, (i == 11) ? 2'b11 : good(i), i == 11, 1'b0, 1'b0, ber_late_chk, i);

    phase = "hold_c";
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, ber_late_chk, 1);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, ber_late_chk, 2);

    // Relock with idle gaps: only strobed headers count towards the window.
    phase = "relock_gaps";
    for (int i = 1; i <= 64; i++) begin
      if (i % 8 == 0) step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, ber_late_chk, -i);
      step(1'b1, good(i), 1'b0, i == 64, 1'b0, ber_late_chk, i);
    end
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, ber_late_chk, 0);

    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
